// File: rtl/led_pattern_sel.sv
// LED pattern selector: debounced push button cycles through N pattern buses,
// blanking the LEDs for a few cycles after each switch.
module led_pattern_sel #(
    parameter int N_LEDS          = 4,
    parameter int N_PATTERNS      = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_CYCLES    = 8,
    localparam int SEL_W = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_btn,
    input  logic [N_PATTERNS*N_LEDS-1:0] i_patterns,
    output logic [N_LEDS-1:0]            o_leds,
    output logic [SEL_W-1:0]             o_sel,
    output logic                         o_switch,
    output logic                         o_blank
);

    localparam int CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BCNT_W     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLANK_INIT = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    typedef enum logic {
        IDLE,
        BLANK
    } state_t;

    logic              sync1_q, sync2_q;
    logic              stable_q, stable_d, stable_d1_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              press;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              blank_q, blank_d;
    logic              switch_q, switch_d;

    // Counter only runs while the synchronised level disagrees with the accepted one
    always_comb begin
        cnt_inc  = cnt_q + CNT_W'(1);
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign press = stable_q & ~stable_d1_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        bcnt_d   = bcnt_q;
        blank_d  = blank_q;
        switch_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    sel_d    = (sel_q == SEL_W'(N_PATTERNS - 1)) ? '0 : sel_q + SEL_W'(1);
                    switch_d = 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        bcnt_d  = BCNT_W'(BLANK_INIT);
                        blank_d = 1'b1;
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                // Presses arriving here are intentionally dropped
                if (bcnt_q == '0) begin
                    blank_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    bcnt_d = bcnt_q - BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            stable_q    <= 1'b0;
            stable_d1_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            sel_q       <= '0;
            bcnt_q      <= '0;
            blank_q     <= 1'b0;
            switch_q    <= 1'b0;
        end else begin
            sync1_q     <= i_btn;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            stable_d1_q <= stable_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            bcnt_q      <= bcnt_d;
            blank_q     <= blank_d;
            switch_q    <= switch_d;
        end
    end

    always_comb begin
        o_leds = '0;
        if (!blank_q) begin
            for (int k = 0; k < N_PATTERNS; k++) begin
                if (sel_q == SEL_W'(k)) begin
                    o_leds = i_patterns[k*N_LEDS +: N_LEDS];
                end
            end
        end
    end

    assign o_sel    = sel_q;
    assign o_switch = switch_q;
    assign o_blank  = blank_q;

endmodule

// File: tb/tb_led_pattern_sel.sv
// Directed bench for led_pattern_sel: debounce timing, wrap, glitch
// rejection, presses dropped while blanking, async reset.
module tb_led_pattern_sel;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic        btn2 = 1'b0;
    logic [11:0] pats = {4'hF, 4'hA, 4'h1};

    logic [3:0]  leds, leds2;
    logic [1:0]  sel, sel2;
    logic        sw, sw2, blank, blank2;

    int checks = 0;
    int errors = 0;
    int sw_cnt = 0;
    int sw2_cnt = 0;

    always #5 clk = ~clk;

    led_pattern_sel #(
        .N_LEDS(4), .N_PATTERNS(3), .DEBOUNCE_CYCLES(4), .BLANK_CYCLES(3)
    ) dut (
        .clk(clk), .i_reset(rst), .i_btn(btn), .i_patterns(pats),
        .o_leds(leds), .o_sel(sel), .o_switch(sw), .o_blank(blank)
    );

    led_pattern_sel #(
        .N_LEDS(4), .N_PATTERNS(3), .DEBOUNCE_CYCLES(1), .BLANK_CYCLES(3)
    ) dut2 (
        .clk(clk), .i_reset(rst), .i_btn(btn2), .i_patterns(pats),
        .o_leds(leds2), .o_sel(sel2), .o_switch(sw2), .o_blank(blank2)
    );

    always @(negedge clk) begin
        if (sw) sw_cnt++;
        if (sw2) sw2_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
        btn2 = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic press_release();
        btn = 1'b1;
        cycles(10);
        btn = 1'b0;
        cycles(10);
    endtask

    int base;
    logic [3:0] exp_leds;

    initial begin
        // 1: reset state
        do_reset();
        check("rst_leds", 32'(leds), 32'h1);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_switch", 32'(sw), 32'd0);

        // 2: held button, accept after edge 6, 3 blank cycles
        base = sw_cnt;
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            exp_leds = (k < 6) ? 4'h1 : (k < 9) ? 4'h0 : 4'hA;
            check($sformatf("hold_sw_%0d", k), 32'(sw), 32'(k == 6));
            check($sformatf("hold_sel_%0d", k), 32'(sel), 32'(k >= 6));
            check($sformatf("hold_blank_%0d", k), 32'(blank),
                  32'(k >= 6 && k < 9));
            check($sformatf("hold_leds_%0d", k), 32'(leds), 32'(exp_leds));
        end
        btn = 1'b0;
        cycles(10);
        check("hold_one_press", 32'(sw_cnt - base), 32'd1);

        // 3: three presses wrap 1,2,0
        do_reset();
        base = sw_cnt;
        press_release();
        check("wrap_sel1", 32'(sel), 32'd1);
        check("wrap_leds1", 32'(leds), 32'hA);
        press_release();
        check("wrap_sel2", 32'(sel), 32'd2);
        check("wrap_leds2", 32'(leds), 32'hF);
        press_release();
        check("wrap_sel0", 32'(sel), 32'd0);
        check("wrap_leds0", 32'(leds), 32'h1);
        check("wrap_switches", 32'(sw_cnt - base), 32'd3);

        // 4: 3-cycle glitches never reach the debounce threshold
        base = sw_cnt;
        for (int r = 0; r < 5; r++) begin
            btn = 1'b1;
            cycles(3);
            btn = 1'b0;
            cycles(5);
        end
        cycles(5);
        check("glitch_switches", 32'(sw_cnt - base), 32'd0);
        check("glitch_sel", 32'(sel), 32'd0);
        check("glitch_leds", 32'(leds), 32'h1);

        // 5: second press accepted while blanking is dropped (DEBOUNCE=1)
        do_reset();
        base = sw2_cnt;
        btn2 = 1'b1;
        cycles(1);
        btn2 = 1'b0;
        cycles(1);
        btn2 = 1'b1;
        cycles(1);
        btn2 = 1'b0;
        cycles(10);
        check("drop_switches", 32'(sw2_cnt - base), 32'd1);
        check("drop_sel", 32'(sel2), 32'd1);
        check("drop_leds", 32'(leds2), 32'hA);

        // 6: async reset in the middle of BLANK with sel=2
        do_reset();
        press_release();
        btn = 1'b1;
        cycles(8);
        check("mid_blank", 32'(blank), 32'd1);
        check("mid_sel", 32'(sel), 32'd2);
        rst = 1'b1;
        btn = 1'b0;
        #1;
        check("async_blank", 32'(blank), 32'd0);
        check("async_sel", 32'(sel), 32'd0);
        cycles(2);
        rst = 1'b0;
        base = sw_cnt;
        cycles(12);
        check("post_rst_leds", 32'(leds), 32'h1);
        check("post_rst_sel", 32'(sel), 32'd0);
        check("post_rst_nopress", 32'(sw_cnt - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
